// File: rtl/pid_ss_gen2_if.sv
// Sample/command bundle between the inertial interface and the balance controller.
// The master modport drives samples and the slave modport returns the drive command.
interface pid_ss_gen2_if #(
    parameter int unsigned KP_W  = 5,
    parameter int unsigned OUT_W = 12
);
    logic                    vld;
    logic signed [15:0]      ptch;
    logic signed [15:0]      ptch_rt;
    logic        [KP_W-1:0]  kp;
    logic                    pwr_up;
    logic                    rider_off;
    logic signed [OUT_W-1:0] PID_cntrl;
    logic                    cntrl_vld;
    logic        [7:0]       ss_tmr;
    logic                    int_sat;

    modport master (
        output vld, ptch, ptch_rt, kp, pwr_up, rider_off,
        input  PID_cntrl, cntrl_vld, ss_tmr, int_sat
    );

    modport slave (
        input  vld, ptch, ptch_rt, kp, pwr_up, rider_off,
        output PID_cntrl, cntrl_vld, ss_tmr, int_sat
    );
endinterface

// File: rtl/pid_ss_gen2.sv
// Two-stage PID balance controller with a saturating anti-windup integrator and a
// soft-start limiter that ramps the allowed command magnitude after power-up.
module pid_ss_gen2 #(
    parameter int unsigned ERR_W   = 10,
    parameter int unsigned OUT_W   = 12,
    parameter int unsigned INT_W   = 18,
    parameter int unsigned KP_W    = 5,
    parameter int unsigned I_SHIFT = 6,
    parameter int unsigned D_SHIFT = 6,
    parameter int unsigned SS_INC  = 1
) (
    input logic          clk,
    input logic          rst_n,
    pid_ss_gen2_if.slave bus
);
    localparam int unsigned P_W   = ERR_W + KP_W + 1;
    localparam int unsigned PI_W  = (P_W > INT_W) ? P_W : INT_W;
    localparam int unsigned SUM_W = ((PI_W > 17) ? PI_W : 17) + 2;

    localparam logic signed [15:0] ERR_HI = 16'(2 ** (ERR_W - 1) - 1);
    localparam logic signed [15:0] ERR_LO = 16'(-(2 ** (ERR_W - 1)));
    localparam logic signed [INT_W-1:0] INT_HI = {1'b0, {(INT_W - 1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_LO = {1'b1, {(INT_W - 1){1'b0}}};
    localparam logic signed [SUM_W-1:0] OUT_HI = SUM_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] OUT_LO = SUM_W'(-(2 ** (OUT_W - 1)));

    logic signed [ERR_W-1:0] err;
    logic signed [ERR_W-1:0] err_q;
    logic signed [15:0]      rt_q;
    logic        [KP_W-1:0]  kp_q;
    logic                    s1_vld_q;
    logic signed [INT_W-1:0] integ_q, integ_d;
    logic signed [INT_W:0]   int_sum;
    logic        [26:0]      long_q, long_d;
    logic        [27:0]      long_sum;
    logic        [7:0]       ss_tmr;
    logic signed [P_W-1:0]   p_term;
    logic signed [INT_W-1:0] i_term;
    logic signed [16:0]      d_term;
    logic signed [SUM_W-1:0] sum, lim, clamped;
    logic signed [OUT_W-1:0] pid_d, pid_q;
    logic                    cntrl_vld_q;

    always_comb begin
        if (bus.ptch > ERR_HI) begin
            err = ERR_HI[ERR_W-1:0];
        end else if (bus.ptch < ERR_LO) begin
            err = ERR_LO[ERR_W-1:0];
        end else begin
            err = bus.ptch[ERR_W-1:0];
        end
    end

    // One extra bit of headroom exposes overflow so the integrator pins at a rail.
    always_comb begin
        int_sum = $signed({integ_q[INT_W-1], integ_q})
                + $signed({{(INT_W + 1 - ERR_W){err[ERR_W-1]}}, err});
        integ_d = integ_q;
        if (!bus.pwr_up || bus.rider_off) begin
            integ_d = '0;
        end else if (bus.vld) begin
            if (int_sum[INT_W] != int_sum[INT_W-1]) begin
                integ_d = int_sum[INT_W] ? INT_LO : INT_HI;
            end else begin
                integ_d = int_sum[INT_W-1:0];
            end
        end
    end

    assign ss_tmr = long_q[26:19];

    // Timer freezes once the visible level tops out; a large increment pins it high.
    always_comb begin
        long_sum = {1'b0, long_q} + 28'(SS_INC);
        long_d   = long_q;
        if (!bus.pwr_up) begin
            long_d = '0;
        end else if (ss_tmr != 8'hFF) begin
            long_d = long_sum[27] ? '1 : long_sum[26:0];
        end
    end

    always_comb begin
        p_term = $signed({1'b0, kp_q}) * err_q;
        i_term = integ_q >>> I_SHIFT;
        d_term = -($signed({rt_q[15], rt_q}) >>> D_SHIFT);
        sum    = SUM_W'(p_term) + SUM_W'(i_term) + SUM_W'(d_term);
        lim    = SUM_W'(ss_tmr) << (OUT_W - 9);
        if (sum > OUT_HI) begin
            clamped = OUT_HI;
        end else if (sum < OUT_LO) begin
            clamped = OUT_LO;
        end else begin
            clamped = sum;
        end
        if (ss_tmr != 8'hFF) begin
            if (clamped > lim) begin
                clamped = lim;
            end else if (clamped < -lim) begin
                clamped = -lim;
            end
        end
        pid_d = clamped[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q       <= '0;
            rt_q        <= '0;
            kp_q        <= '0;
            s1_vld_q    <= 1'b0;
            integ_q     <= '0;
            long_q      <= '0;
            pid_q       <= '0;
            cntrl_vld_q <= 1'b0;
        end else begin
            s1_vld_q    <= bus.vld;
            if (bus.vld) begin
                err_q <= err;
                rt_q  <= bus.ptch_rt;
                kp_q  <= bus.kp;
            end
            integ_q     <= integ_d;
            long_q      <= long_d;
            cntrl_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                pid_q <= pid_d;
            end
        end
    end

    assign bus.PID_cntrl = pid_q;
    assign bus.cntrl_vld = cntrl_vld_q;
    assign bus.ss_tmr    = ss_tmr;
    assign bus.int_sat   = (integ_q == INT_HI) || (integ_q == INT_LO);
endmodule

// File: tb/tb_pid_ss_gen2.sv
// Self-checking bench for pid_ss_gen2: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_pid_ss_gen2;
    localparam int    I_SH   = 6;
    localparam int    D_SH   = 6;
    localparam longint SSINC = 2 ** 18;
    localparam int    INT_MX = 131071;
    localparam int    INT_MN = -131072;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    pid_ss_gen2_if #(.KP_W(5), .OUT_W(12)) bus ();

    pid_ss_gen2 #(.SS_INC(2 ** 18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int err;
        int rt;
        int kp;
        int due;
    } samp_t;

    samp_t  pq[$];
    int     m_integ;
    longint m_n;
    int     m_edge;
    int     exp_out;
    logic   exp_vld;

    function automatic int clampi(int v, int lo, int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int level(longint n);
        longint v;
        v = (n * SSINC) >> 19;
        return (v > 255) ? 255 : int'(v);
    endfunction

    function automatic int pid_ref(int err, int rt, int kp, int integ, int lvl);
        int s;
        s = kp * err + (integ >>> I_SH) - (rt >>> D_SH);
        s = clampi(s, -2048, 2047);
        if (lvl != 255) s = clampi(s, -lvl * 8, lvl * 8);
        return s;
    endfunction

    function automatic logic model_sat();
        return (m_integ == INT_MX) || (m_integ == INT_MN);
    endfunction

    task automatic model_reset();
        m_integ = 0;
        m_n     = 0;
        m_edge  = 0;
        exp_out = 0;
        exp_vld = 1'b0;
        pq.delete();
    endtask

    // Applies the specification's per-edge rules to the inputs present at the edge.
    task automatic model_edge();
        int lvl;
        int err;
        samp_t s;
        lvl     = level(m_n);
        exp_vld = 1'b0;
        if (pq.size() > 0 && pq[0].due == m_edge) begin
            s       = pq.pop_front();
            exp_out = pid_ref(s.err, s.rt, s.kp, m_integ, lvl);
            exp_vld = 1'b1;
        end
        err = clampi(int'(bus.ptch), -512, 511);
        if (!bus.pwr_up || bus.rider_off) m_integ = 0;
        else if (bus.vld) m_integ = clampi(m_integ + err, INT_MN, INT_MX);
        if (bus.vld) pq.push_back('{err, int'(bus.ptch_rt), int'(bus.kp), m_edge + 1});
        if (!bus.pwr_up) m_n = 0;
        else if (m_n < 100000) m_n = m_n + 1;
        m_edge = m_edge + 1;
    endtask

    task automatic step(input logic v, input logic [15:0] p, input logic [15:0] r,
                        input logic [4:0] k);
        bus.vld     = v;
        bus.ptch    = p;
        bus.ptch_rt = r;
        bus.kp      = k;
        @(posedge clk);
        model_edge();
        #1;
        bus.vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total += 4;
        if (bus.PID_cntrl !== 12'sd0) begin
            bad++; $display("FAIL reset_pid: got %0d want 0", bus.PID_cntrl);
        end
        if (bus.cntrl_vld !== 1'b0) begin
            bad++; $display("FAIL reset_vld: got %b want 0", bus.cntrl_vld);
        end
        if (bus.ss_tmr !== 8'd0) begin
            bad++; $display("FAIL reset_ss: got %0d want 0", bus.ss_tmr);
        end
        if (bus.int_sat !== 1'b0) begin
            bad++; $display("FAIL reset_sat: got %b want 0", bus.int_sat);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_prop_int();
        bus.pwr_up = 1'b1;
        repeat (600) step(1'b0, 16'd0, 16'd0, 5'd0);
        total += 2;
        if (bus.ss_tmr !== 8'hFF) begin
            bad++; $display("FAIL pi_ss_full: got %0d want 255", bus.ss_tmr);
        end
        if (int'(bus.ss_tmr) != level(m_n)) begin
            bad++; $display("FAIL pi_ss_model: got %0d want %0d", bus.ss_tmr, level(m_n));
        end
        step(1'b1, 16'd100, 16'd0, 5'd9);
        total++;
        if (bus.cntrl_vld !== 1'b0) begin
            bad++; $display("FAIL pi_early_vld: got %b want 0", bus.cntrl_vld);
        end
        step(1'b0, 16'd0, 16'd0, 5'd0);
        total += 3;
        if (bus.cntrl_vld !== 1'b1) begin
            bad++; $display("FAIL pi_vld: got %b want 1", bus.cntrl_vld);
        end
        if (bus.PID_cntrl !== 12'sd901) begin
            bad++; $display("FAIL pi_value: got %0d want 901", bus.PID_cntrl);
        end
        if (int'(bus.PID_cntrl) != exp_out) begin
            bad++; $display("FAIL pi_model: got %0d want %0d", bus.PID_cntrl, exp_out);
        end
        step(1'b0, 16'd0, 16'd0, 5'd0);
        total += 2;
        if (bus.cntrl_vld !== 1'b0) begin
            bad++; $display("FAIL pi_pulse: got %b want 0", bus.cntrl_vld);
        end
        if (bus.PID_cntrl !== 12'sd901) begin
            bad++; $display("FAIL pi_hold: got %0d want 901", bus.PID_cntrl);
        end
    endtask

    task automatic test_d_sat();
        logic [15:0] pv[3];
        logic [15:0] rv[3];
        int          want[3];
        pv = '{16'd0, 16'h7FFF, 16'h8000};
        rv = '{16'd6400, 16'd0, 16'd0};
        want = '{-100, 2047, -2048};
        bus.rider_off = 1'b1;
        step(1'b0, 16'd0, 16'd0, 5'd0);
        bus.rider_off = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pv[i], rv[i], 5'd9);
            step(1'b0, 16'd0, 16'd0, 5'd0);
            total += 2;
            if (bus.cntrl_vld !== 1'b1 || int'(bus.PID_cntrl) != want[i]) begin
                bad++;
                $display("FAIL dsat_%0d: got vld=%b val=%0d want vld=1 val=%0d",
                         i, bus.cntrl_vld, bus.PID_cntrl, want[i]);
            end
            if (int'(bus.PID_cntrl) != exp_out) begin
                bad++; $display("FAIL dsat_model_%0d: got %0d want %0d", i, bus.PID_cntrl, exp_out);
            end
        end
    endtask

    task automatic test_windup();
        bus.rider_off = 1'b1;
        step(1'b0, 16'd0, 16'd0, 5'd0);
        bus.rider_off = 1'b0;
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 16'h7FFF, 16'd0, 5'd0);
            total++;
            if (bus.int_sat !== model_sat()) begin
                bad++; $display("FAIL windup_sat_%0d: got %b want %b", i, bus.int_sat, model_sat());
            end
            if (i == 255) begin
                total++;
                if (bus.int_sat !== 1'b0) begin
                    bad++; $display("FAIL windup_256: got %b want 0", bus.int_sat);
                end
            end
            if (i == 256) begin
                total++;
                if (bus.int_sat !== 1'b1) begin
                    bad++; $display("FAIL windup_257: got %b want 1", bus.int_sat);
                end
            end
        end
        step(1'b1, 16'hFFFF, 16'd0, 5'd0);
        total += 2;
        if (bus.int_sat !== 1'b0) begin
            bad++; $display("FAIL windup_release: got %b want 0", bus.int_sat);
        end
        if (m_integ != 131070) begin
            bad++; $display("FAIL windup_model: got %0d want 131070", m_integ);
        end
        step(1'b0, 16'd0, 16'd0, 5'd0);
        step(1'b0, 16'd0, 16'd0, 5'd0);
        total++;
        if (bus.PID_cntrl !== 12'sd2047) begin
            bad++; $display("FAIL windup_out: got %0d want 2047", bus.PID_cntrl);
        end
    endtask

    task automatic test_rider_off();
        bus.rider_off = 1'b1;
        step(1'b0, 16'd0, 16'd0, 5'd0);
        bus.rider_off = 1'b0;
        repeat (10) step(1'b1, 16'd500, 16'd0, 5'd0);
        step(1'b0, 16'd0, 16'd0, 5'd0);
        total++;
        if (bus.PID_cntrl !== 12'sd78) begin
            bad++; $display("FAIL rider_i5000: got %0d want 78", bus.PID_cntrl);
        end
        bus.rider_off = 1'b1;
        step(1'b0, 16'd0, 16'd0, 5'd0);
        bus.rider_off = 1'b0;
        total++;
        if (m_integ != 0 || bus.int_sat !== 1'b0) begin
            bad++; $display("FAIL rider_clear: got sat=%b want 0 (model integ %0d)", bus.int_sat, m_integ);
        end
        step(1'b1, 16'd0, 16'd0, 5'd0);
        step(1'b0, 16'd0, 16'd0, 5'd0);
        total++;
        if (bus.PID_cntrl !== 12'sd0 || int'(bus.PID_cntrl) != exp_out) begin
            bad++; $display("FAIL rider_i0: got %0d want 0", bus.PID_cntrl);
        end
        repeat (3) step(1'b1, 16'd500, 16'd0, 5'd0);
        bus.rider_off = 1'b1;
        step(1'b1, 16'd500, 16'd0, 5'd1);
        bus.rider_off = 1'b0;
        step(1'b0, 16'd0, 16'd0, 5'd0);
        total += 2;
        if (bus.PID_cntrl !== 12'sd500) begin
            bad++; $display("FAIL rider_same_edge: got %0d want 500", bus.PID_cntrl);
        end
        if (int'(bus.PID_cntrl) != exp_out) begin
            bad++; $display("FAIL rider_model: got %0d want %0d", bus.PID_cntrl, exp_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        for (int i = 0; i < 300; i++) begin
            p = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                            : 16'(int'($urandom_range(0, 1200)) - 600);
            bus.rider_off = ($urandom_range(0, 15) == 0);
            step(($urandom_range(0, 3) != 0), p, 16'($urandom), 5'($urandom));
            total += 3;
            if (bus.cntrl_vld !== exp_vld) begin
                bad++; $display("FAIL b2b_vld_%0d: got %b want %b", i, bus.cntrl_vld, exp_vld);
            end
            if (int'(bus.PID_cntrl) != exp_out) begin
                bad++; $display("FAIL b2b_val_%0d: got %0d want %0d", i, bus.PID_cntrl, exp_out);
            end
            if (bus.int_sat !== model_sat()) begin
                bad++; $display("FAIL b2b_sat_%0d: got %b want %b", i, bus.int_sat, model_sat());
            end
        end
        bus.rider_off = 1'b0;
        repeat (3) step(1'b0, 16'd0, 16'd0, 5'd0);
    endtask

    task automatic test_soft_start();
        int want[2];
        bit hit;
        want = '{80, -80};
        bus.rider_off = 1'b1;
        bus.pwr_up    = 1'b0;
        repeat (3) step(1'b0, 16'd0, 16'd0, 5'd0);
        bus.pwr_up = 1'b1;
        step(1'b1, 16'd100, 16'd0, 5'd9);
        step(1'b0, 16'd0, 16'd0, 5'd0);
        total += 2;
        if (bus.cntrl_vld !== 1'b1 || bus.PID_cntrl !== 12'sd0) begin
            bad++; $display("FAIL ss_zero: got vld=%b val=%0d want vld=1 val=0", bus.cntrl_vld, bus.PID_cntrl);
        end
        if (int'(bus.ss_tmr) != level(m_n)) begin
            bad++; $display("FAIL ss_level: got %0d want %0d", bus.ss_tmr, level(m_n));
        end
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (m_n == 19) hit = 1'b1;
            else step(1'b0, 16'd0, 16'd0, 5'd0);
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL ss_reach: got n=%0d want 19", m_n);
        end
        step(1'b1, 16'd100, 16'd0, 5'd9);
        step(1'b1, 16'hFF9C, 16'd0, 5'd9);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) step(1'b0, 16'd0, 16'd0, 5'd0);
            total += 2;
            if (bus.cntrl_vld !== 1'b1 || int'(bus.PID_cntrl) != want[i]) begin
                bad++; $display("FAIL ss_ten_%0d: got vld=%b val=%0d want vld=1 val=%0d",
                                i, bus.cntrl_vld, bus.PID_cntrl, want[i]);
            end
            if (int'(bus.PID_cntrl) != exp_out) begin
                bad++; $display("FAIL ss_model_%0d: got %0d want %0d", i, bus.PID_cntrl, exp_out);
            end
        end
        repeat (600) step(1'b0, 16'd0, 16'd0, 5'd0);
        total++;
        if (bus.ss_tmr !== 8'hFF) begin
            bad++; $display("FAIL ss_full: got %0d want 255", bus.ss_tmr);
        end
        repeat (20) step(1'b0, 16'd0, 16'd0, 5'd0);
        total++;
        if (bus.ss_tmr !== 8'hFF) begin
            bad++; $display("FAIL ss_freeze: got %0d want 255", bus.ss_tmr);
        end
        bus.rider_off = 1'b0;
    endtask

    task automatic test_reset_flight();
        step(1'b1, 16'd300, 16'd0, 5'd7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total += 4;
        if (bus.cntrl_vld !== 1'b0 || bus.PID_cntrl !== 12'sd0) begin
            bad++; $display("FAIL rst_out: got vld=%b val=%0d want 0 0", bus.cntrl_vld, bus.PID_cntrl);
        end
        if (bus.ss_tmr !== 8'd0) begin
            bad++; $display("FAIL rst_ss: got %0d want 0", bus.ss_tmr);
        end
        if (bus.int_sat !== 1'b0) begin
            bad++; $display("FAIL rst_sat: got %b want 0", bus.int_sat);
        end
        @(posedge clk);
        #1;
        if (bus.cntrl_vld !== 1'b0) begin
            bad++; $display("FAIL rst_hold_vld: got %b want 0", bus.cntrl_vld);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'd0, 16'd0, 5'd0);
            total += 2;
            if (bus.cntrl_vld !== 1'b0) begin
                bad++; $display("FAIL rst_ghost_%0d: got %b want 0", i, bus.cntrl_vld);
            end
            if (int'(bus.ss_tmr) != level(m_n)) begin
                bad++; $display("FAIL rst_ss_ramp_%0d: got %0d want %0d", i, bus.ss_tmr, level(m_n));
            end
        end
    endtask

    initial begin
        bus.vld       = 1'b0;
        bus.ptch      = '0;
        bus.ptch_rt   = '0;
        bus.kp        = '0;
        bus.pwr_up    = 1'b0;
        bus.rider_off = 1'b0;
        model_reset();
        test_reset();
        test_prop_int();
        test_d_sat();
        test_windup();
        test_rider_off();
        test_back_to_back();
        test_soft_start();
        test_reset_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pid_ss_gen2.md
Name: pid_ss_gen2

Overview:
- Parametrised second-generation balance controller for the segway datapath.
- Takes signed pitch and pitch rate. Produces a saturated PID drive command with runtime-programmable proportional gain, a saturating anti-windup integrator, and a 2-stage registered pipeline with output-valid.
- A soft-start limiter clamps command magnitude to a ramp derived from an internal power-up timer.
- Sits between the inertial interface and the motor-balance mixer.

Parameters:
ERR_W, 10, signed width that pitch error is saturated to
OUT_W, 12, signed width of PID_cntrl (legal range 10..16)
INT_W, 18, signed integrator width
KP_W, 5, unsigned width of runtime P gain
I_SHIFT, 6, arithmetic right shift applied to integrator for I term
D_SHIFT, 6, arithmetic right shift applied to ptch_rt for D term
SS_INC, 1, soft-start timer increment per clk (bench uses 2**18)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
vld  input  1  new ptch/ptch_rt sample strobe
ptch  input  16  signed pitch
ptch_rt  input  16  signed pitch rate
kp  input  KP_W  unsigned P gain, sampled with vld
pwr_up  input  1  low holds soft-start timer and integrator at 0
rider_off  input  1  high clears integrator
PID_cntrl  output  OUT_W  signed drive command
cntrl_vld  output  1  1-cycle pulse, PID_cntrl updated
ss_tmr  output  8  soft-start level, 0..255
int_sat  output  1  integrator currently at a clamp rail

Behaviour:
- Reset: already decided — reset rst_n, asynchronous, active-low; clock clk. All registers clear. PID_cntrl=0, cntrl_vld=0, ss_tmr=0, int_sat=0.
- Error sat: err = ptch clamped to [-2^(ERR_W-1), 2^(ERR_W-1)-1].
- Stage 1 (cycle after vld): register err, ptch_rt, kp; set s1_vld.
- Integrator update, same edge as stage 1:
  - Priority: !pwr_up or rider_off → integrator=0, int_sat=0.
  - Else on vld: integrator = clamp(integrator + sext(err)) to INT_W signed range. Saturating, never frozen.
  - int_sat=1 while the value equals either rail.
- Stage 2 (cycle after s1_vld):
  - P = kp*err (unsigned kp zero-extended, signed product).
  - I = integrator >>> I_SHIFT, using the post-update integrator.
  - D = -(ptch_rt >>> D_SHIFT).
  - Sum = P+I+D, full precision with no intermediate wrap.
  - Saturate sum to OUT_W signed.
  - Soft-start clamp: lim = ss_tmr << (OUT_W-9). If ss_tmr != 8'hFF, clamp the result to [-lim, +lim]. At 8'hFF the clamp is bypassed.
  - Register result into PID_cntrl and pulse cntrl_vld.
- Latency: vld at edge N → PID_cntrl/cntrl_vld at edge N+2. Back-to-back vld every cycle is supported: fully pipelined, one result per vld.
- PID_cntrl holds its value between cntrl_vld pulses.
- Soft-start timer: 27-bit long_tmr.
  - !pwr_up → 0.
  - Else add SS_INC unless long_tmr[26:19]==8'hFF. Once there it freezes and never wraps.
  - ss_tmr = long_tmr[26:19].
- rider_off while a sample is in flight: stage 2 uses the cleared integrator (0) if the clear edge coincides with the stage-1 edge.
- pwr_up falling mid-run: ss_tmr→0 next edge, so subsequent outputs clamp to 0. In-flight cntrl_vld pulses still occur.
- Async reset mid-pipeline: in-flight samples are discarded and no cntrl_vld is emitted.

Test Plan:
- Proportional and integral: SS_INC=2**18, pwr_up=1 for 600 cycles (ss_tmr=FF); single vld with ptch=100, ptch_rt=0, kp=9 → PID_cntrl=901 (900+1) exactly 2 cycles later, cntrl_vld one-cycle pulse.
- D term and saturation:
  - ptch=0, ptch_rt=6400, integrator 0 → PID_cntrl=-100.
  - ptch=16'h7FFF, kp=9 → 2047.
  - ptch=16'h8000 → -2048.
- Anti-windup: 260 consecutive vld with ptch=16'h7FFF → integrator reaches 131071 on the 257th, int_sat=1, value held. One vld with ptch=-1 → 131070, int_sat=0.
- Soft start: pwr_up rises; sample at ss_tmr=0 → PID_cntrl=0. At ss_tmr=10 with demand 900 → 80. At ss_tmr=10 with demand -900 → -80. Confirm ss_tmr freezes at FF.
- rider_off pulse after integrator=5000 → integrator 0 next edge; next result has I=0. Same-edge vld+rider_off → integrator 0.
- Reset: assert rst_n low one cycle after vld → no cntrl_vld; all outputs 0; ss_tmr restarts from 0.
